// File: rtl/sram_write_monitor.sv
// Snoops SRAM writes and checks each one against an expected-data ROM. Keeps a
// per-location written bitmap over a region, then sweeps it for unwritten words.
module sram_write_monitor #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REGION_LO  = 146944,
    parameter int unsigned REGION_HI  = 262143,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  Clock_50,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] SRAM_address,
    input  logic [DATA_WIDTH-1:0] SRAM_write_data,
    input  logic                  SRAM_we_n,
    output logic [ADDR_WIDTH-1:0] Exp_address,
    input  logic [DATA_WIDTH-1:0] Exp_read_data,
    input  logic                  Check_start,
    input  logic                  Clear,
    output logic                  Busy,
    output logic                  Done,
    output logic [CNT_WIDTH-1:0]  Mismatch_count,
    output logic [CNT_WIDTH-1:0]  Out_of_region_count,
    output logic [CNT_WIDTH-1:0]  Multi_write_count,
    output logic [CNT_WIDTH-1:0]  Unwritten_count,
    output logic [ADDR_WIDTH-1:0] First_mismatch_address,
    output logic                  First_mismatch_valid
);
    localparam int unsigned R    = REGION_HI - REGION_LO + 1;
    localparam int unsigned BmW  = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned IdxW = $clog2(R + 1);
    localparam logic [ADDR_WIDTH-1:0] LoA      = ADDR_WIDTH'(REGION_LO);
    localparam logic [ADDR_WIDTH-1:0] HiA      = ADDR_WIDTH'(REGION_HI);
    localparam logic [IdxW-1:0]       LastIdx  = IdxW'(R - 1);
    localparam logic [IdxW-1:0]       SweepEnd = IdxW'(R);

    typedef enum logic [1:0] {StClear, StMonitor, StSweep, StDone} state_e;

    state_e                state_q;
    logic [IdxW-1:0]       idx_q;
    logic                  sweep_vld_q;
    logic [ADDR_WIDTH-1:0] exp_addr_q;
    logic                  s1_valid_q, s1_inreg_q, fwd_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [BmW-1:0]        s1_idx_q;
    logic [CNT_WIDTH-1:0]  mis_q, oor_q, multi_q, unw_q;
    logic [ADDR_WIDTH-1:0] fm_addr_q;
    logic                  fm_valid_q;

    logic                  bitmap_q [R];
    logic                  bm_rd_q;
    logic                  bm_we, bm_wdata;
    logic [BmW-1:0]        bm_waddr, bm_raddr;

    logic                  in_region, take, fwd_d;
    logic                  s2_mismatch, s2_set, s2_multi, s2_oor;
    logic [ADDR_WIDTH-1:0] offset;
    logic [BmW-1:0]        wr_idx_in;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_region = (SRAM_address >= LoA) && (SRAM_address <= HiA);
    assign offset    = SRAM_address - LoA;
    assign wr_idx_in = BmW'(offset);
    assign take      = (state_q == StMonitor) && !SRAM_we_n && !Check_start && !Clear;

    assign Exp_address = ((state_q == StMonitor) && !SRAM_we_n) ? SRAM_address : exp_addr_q;

    assign s2_mismatch = s1_valid_q && (s1_data_q != Exp_read_data);
    assign s2_set      = s1_valid_q && s1_inreg_q;
    assign s2_multi    = s2_set && (bm_rd_q || fwd_q);
    assign s2_oor      = s1_valid_q && !s1_inreg_q;
    // The bitmap read for a back-to-back write to the same word misses the set
    // being written this cycle, so carry it forward as a flag.
    assign fwd_d       = take && in_region && s2_set && (wr_idx_in == s1_idx_q);

    always_comb begin
        bm_we    = 1'b0;
        bm_wdata = 1'b1;
        bm_waddr = s1_idx_q;
        bm_raddr = wr_idx_in;
        if (state_q == StClear) begin
            bm_we    = 1'b1;
            bm_wdata = 1'b0;
            bm_waddr = BmW'(idx_q);
        end else if (s2_set) begin
            bm_we = 1'b1;
        end
        if (state_q == StSweep) bm_raddr = BmW'(idx_q);
    end

    always_ff @(posedge Clock_50) begin
        if (bm_we) bitmap_q[bm_waddr] <= bm_wdata;
        bm_rd_q <= bitmap_q[bm_raddr];
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q     <= StClear;
            idx_q       <= '0;
            sweep_vld_q <= 1'b0;
            exp_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_inreg_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
            fwd_q       <= 1'b0;
            mis_q       <= '0;
            oor_q       <= '0;
            multi_q     <= '0;
            unw_q       <= '0;
            fm_addr_q   <= '0;
            fm_valid_q  <= 1'b0;
        end else begin
            if ((state_q == StMonitor) && !SRAM_we_n) exp_addr_q <= SRAM_address;
            s1_valid_q  <= take;
            fwd_q       <= fwd_d;
            sweep_vld_q <= (state_q == StSweep) && (idx_q != SweepEnd);
            if (take) begin
                s1_addr_q  <= SRAM_address;
                s1_data_q  <= SRAM_write_data;
                s1_inreg_q <= in_region;
                s1_idx_q   <= wr_idx_in;
            end
            if (Clear) begin
                state_q     <= StClear;
                idx_q       <= '0;
                sweep_vld_q <= 1'b0;
                mis_q       <= '0;
                oor_q       <= '0;
                multi_q     <= '0;
                unw_q       <= '0;
                fm_addr_q   <= '0;
                fm_valid_q  <= 1'b0;
            end else begin
                if (s2_mismatch) begin
                    mis_q <= sat_inc(mis_q);
                    if (!fm_valid_q) begin
                        fm_addr_q  <= s1_addr_q;
                        fm_valid_q <= 1'b1;
                    end
                end
                if (s2_oor)   oor_q   <= sat_inc(oor_q);
                if (s2_multi) multi_q <= sat_inc(multi_q);
                if (sweep_vld_q && !bm_rd_q) unw_q <= sat_inc(unw_q);
                unique case (state_q)
                    StClear: begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StMonitor;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    StMonitor: begin
                        if (Check_start) begin
                            idx_q   <= '0;
                            state_q <= StSweep;
                        end
                    end
                    StSweep: begin
                        if (idx_q == SweepEnd) state_q <= StDone;
                        else                   idx_q   <= idx_q + 1'b1;
                    end
                    StDone: ;
                endcase
            end
        end
    end

    assign Busy                   = (state_q == StClear) || (state_q == StSweep);
    assign Done                   = (state_q == StDone);
    assign Mismatch_count         = mis_q;
    assign Out_of_region_count    = oor_q;
    assign Multi_write_count      = multi_q;
    assign Unwritten_count        = unw_q;
    assign First_mismatch_address = fm_addr_q;
    assign First_mismatch_valid   = fm_valid_q;
endmodule

// File: tb/tb_sram_write_monitor.sv
// Bench for sram_write_monitor on a 16-word region with ROM word[a] = a, checked
// against a set/counter model of the write history.
module tb_sram_write_monitor;
    localparam int AW = 8, DW = 16, LO = 16, HI = 31, CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          we_n = 1'b1;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rd = '0;
    logic          check_start = 1'b0, clear = 1'b0;
    logic          busy, done, fmv;
    logic [CW-1:0] mis, oor, multi, unw;
    logic [AW-1:0] fma;

    int total = 0;
    int bad = 0;

    bit            written [256];
    int            m_mis, m_oor, m_multi;
    logic [AW-1:0] m_fma;
    bit            m_fmv;

    always #5 clk = ~clk;
    always @(posedge clk) exp_rd <= {8'h00, exp_addr};

    sram_write_monitor #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGION_LO(LO), .REGION_HI(HI), .CNT_WIDTH(CW)
    ) dut (
        .Clock_50(clk), .Reset(rst), .SRAM_address(addr), .SRAM_write_data(wdata),
        .SRAM_we_n(we_n), .Exp_address(exp_addr), .Exp_read_data(exp_rd),
        .Check_start(check_start), .Clear(clear), .Busy(busy), .Done(done),
        .Mismatch_count(mis), .Out_of_region_count(oor), .Multi_write_count(multi),
        .Unwritten_count(unw), .First_mismatch_address(fma), .First_mismatch_valid(fmv)
    );

    function automatic logic [15:0] sat(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic int unw_model();
        int n = 0;
        for (int a = LO; a <= HI; a++) if (!written[a]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 256; a++) written[a] = 1'b0;
        m_mis = 0; m_oor = 0; m_multi = 0; m_fma = '0; m_fmv = 1'b0;
    endtask

    // One write cycle driven at a negedge; the model records its effect.
    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr = a; wdata = d; we_n = 1'b0;
        @(negedge clk);
        we_n = 1'b1;
        if (d != {8'h00, a}) begin
            m_mis++;
            if (!m_fmv) begin m_fmv = 1'b1; m_fma = a; end
        end
        if (a >= LO && a <= HI) begin
            if (written[a]) m_multi++;
            written[a] = 1'b1;
        end else begin
            m_oor++;
        end
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    endtask

    // Check_start pulse, optionally with a write in the same cycle that must be ignored.
    task automatic start_check(input bit with_write, output int n);
        check_start = 1'b1;
        if (with_write) begin addr = 8'd20; wdata = 16'h1234; we_n = 1'b0; end
        @(negedge clk);
        check_start = 1'b0; we_n = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    endtask

    task automatic restart();
        int n;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        wait_not_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL clear_len: got %0d want 16", n); end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (mis !== 0 || oor !== 0 || multi !== 0 || unw !== 0) begin
            bad++; $display("FAIL rst_cnt: got %0d/%0d/%0d/%0d want 0", mis, oor, multi, unw);
        end
        total++; if (fmv !== 1'b0 || fma !== 0) begin
            bad++; $display("FAIL rst_fm: got %b/%0d want 0/0", fmv, fma);
        end
        rst = 1'b0;
        model_clear();
        wait_not_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL rst_clear_len: got %0d want 16", n); end
    endtask

    task automatic test_full_pass();
        int n;
        for (int a = LO; a <= HI; a++) drive_write(8'(a), 16'(a));
        start_check(1'b0, n);
        total++; if (n !== 17) begin bad++; $display("FAIL sweep_len: got %0d want 17", n); end
        total++; if (mis !== sat(m_mis) || multi !== sat(m_multi) || oor !== sat(m_oor)) begin
            bad++; $display("FAIL full_cnt: got %0d/%0d/%0d want 0/0/0", mis, multi, oor);
        end
        total++; if (unw !== 16'(unw_model())) begin
            bad++; $display("FAIL full_unw: got %0d want %0d", unw, unw_model());
        end
        check_start = 1'b1; @(negedge clk); check_start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL done_hold: got done=%b busy=%b want 1/0", done, busy);
        end
        restart();
    endtask

    task automatic test_mismatch();
        int n;
        for (int a = LO; a <= HI; a++) begin
            if (a == 25) continue;
            if (a == 20) begin
                drive_write(8'd20, 16'h00AA);
                total++; if (mis !== 0) begin bad++; $display("FAIL mis_early: got %0d want 0", mis); end
                @(negedge clk);
                total++; if (mis !== 1) begin bad++; $display("FAIL mis_lat: got %0d want 1", mis); end
            end else begin
                drive_write(8'(a), 16'(a));
            end
        end
        start_check(1'b0, n);
        total++; if (mis !== sat(m_mis)) begin
            bad++; $display("FAIL mis_cnt: got %0d want %0d", mis, sat(m_mis));
        end
        total++; if (fmv !== m_fmv || fma !== m_fma) begin
            bad++; $display("FAIL mis_first: got %b/%0d want %b/%0d", fmv, fma, m_fmv, m_fma);
        end
        total++; if (unw !== 16'(unw_model())) begin
            bad++; $display("FAIL mis_unw: got %0d want %0d", unw, unw_model());
        end
        restart();
    endtask

    task automatic test_region();
        int n;
        drive_write(8'd15, 16'd15);
        drive_write(8'd32, 16'd32);
        drive_write(8'd16, 16'd16);
        drive_write(8'd31, 16'd31);
        start_check(1'b0, n);
        total++; if (oor !== sat(m_oor)) begin
            bad++; $display("FAIL region_oor: got %0d want %0d", oor, sat(m_oor));
        end
        total++; if (unw !== 16'(unw_model())) begin
            bad++; $display("FAIL region_unw: got %0d want %0d", unw, unw_model());
        end
        total++; if (mis !== 0 || multi !== 0) begin
            bad++; $display("FAIL region_other: got %0d/%0d want 0/0", mis, multi);
        end
        restart();
    endtask

    task automatic test_back_to_back();
        int n;
        drive_write(8'd18, 16'd18);
        drive_write(8'd18, 16'd18);
        repeat (3) @(negedge clk);
        drive_write(8'd18, 16'd18);
        start_check(1'b0, n);
        total++; if (multi !== sat(m_multi)) begin
            bad++; $display("FAIL b2b_multi: got %0d want %0d", multi, sat(m_multi));
        end
        total++; if (unw !== 16'(unw_model())) begin
            bad++; $display("FAIL b2b_unw: got %0d want %0d", unw, unw_model());
        end
        restart();
    endtask

    task automatic test_clear_priority();
        int n;
        drive_write(8'd40, 16'hBEEF);
        drive_write(8'd17, 16'd17);
        drive_write(8'd17, 16'd17);
        repeat (2) @(negedge clk);
        clear = 1'b1; check_start = 1'b1;
        @(negedge clk);
        clear = 1'b0; check_start = 1'b0;
        model_clear();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL prio_state: got busy=%b done=%b want 1/0", busy, done);
        end
        total++; if (mis !== 0 || oor !== 0 || multi !== 0 || fmv !== 1'b0) begin
            bad++; $display("FAIL prio_cnt: got %0d/%0d/%0d/%b want 0", mis, oor, multi, fmv);
        end
        wait_not_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL prio_clear_len: got %0d want 16", n); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        drive_write(8'd21, 16'h0001);
        drive_write(8'd50, 16'd50);
        check_start = 1'b1; @(negedge clk); check_start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_state: got busy=%b done=%b want 1/0", busy, done);
        end
        total++; if (mis !== 0 || oor !== 0 || unw !== 0 || fmv !== 1'b0) begin
            bad++; $display("FAIL midrst_cnt: got %0d/%0d/%0d/%b want 0", mis, oor, unw, fmv);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        wait_not_busy(n);
        total++; if (n !== 16) begin bad++; $display("FAIL midrst_clear_len: got %0d want 16", n); end
        start_check(1'b0, n);
        total++; if (unw !== 16'(unw_model())) begin
            bad++; $display("FAIL midrst_unw: got %0d want %0d", unw, unw_model());
        end
        restart();
    endtask

    task automatic test_random();
        int n;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < int'($urandom_range(20, 50)); i++) begin
                a = 8'($urandom_range(8, 40));
                d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, a};
                drive_write(a, d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            total++; if (exp_addr !== a) begin
                bad++; $display("FAIL rnd_exp_hold: got %0d want %0d", exp_addr, a);
            end
            start_check(1'($urandom_range(0, 1)), n);
            total++; if (mis !== sat(m_mis) || oor !== sat(m_oor) || multi !== sat(m_multi)) begin
                bad++; $display("FAIL rnd_cnt r%0d: got %0d/%0d/%0d want %0d/%0d/%0d", round,
                                mis, oor, multi, sat(m_mis), sat(m_oor), sat(m_multi));
            end
            total++; if (unw !== 16'(unw_model())) begin
                bad++; $display("FAIL rnd_unw r%0d: got %0d want %0d", round, unw, unw_model());
            end
            total++; if (fmv !== m_fmv || (m_fmv && fma !== m_fma)) begin
                bad++; $display("FAIL rnd_first r%0d: got %b/%0d want %b/%0d", round,
                                fmv, fma, m_fmv, m_fma);
            end
            restart();
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 70000; i++) begin
            addr = 8'(LO + (i % 16)); wdata = 16'hFFFF; we_n = 1'b0;
            @(negedge clk);
            m_mis++;
            if (!m_fmv) begin m_fmv = 1'b1; m_fma = addr; end
            if (written[addr]) m_multi++;
            written[addr] = 1'b1;
        end
        we_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (mis !== sat(m_mis)) begin
            bad++; $display("FAIL sat_mis: got %0h want %0h", mis, sat(m_mis));
        end
        total++; if (multi !== sat(m_multi)) begin
            bad++; $display("FAIL sat_multi: got %0h want %0h", multi, sat(m_multi));
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_mismatch();
        test_region();
        test_back_to_back();
        test_clear_priority();
        test_reset_mid_sweep();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
